// File: rtl/osc_tick_pkg.sv
// -----------------------------------------------------------------------------
// osc_tick_pkg
// Shared types and constants for the oscillator tick generator.
//   OSC_TICK_MAX_NCH : upper bound on the channel count.
//   OSC_TICK_CNT_W   : default divider counter width.
//   chan_cfg_t       : one channel's configuration {en, div}.
//   ch_width()       : channel-index width for a given channel count (min 1).
// -----------------------------------------------------------------------------
package osc_tick_pkg;

   localparam int OSC_TICK_MAX_NCH = 16;
   localparam int OSC_TICK_CNT_W   = 16;

   typedef struct packed {
      logic                      en;
      logic [OSC_TICK_CNT_W-1:0] div;
   } chan_cfg_t;

   // A single channel still needs a one-bit index so cfg_ch stays a real port.
   function automatic int ch_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/osc_tick_chan.sv
// -----------------------------------------------------------------------------
// osc_tick_chan
// One tick channel: down-counter, active divider/enable, a one-deep pending
// configuration slot and the registered tick flop.
// Ports:
//   clk, rst  : oscillator clock, asynchronous active-high reset
//   acc       : configuration accepted for this channel this edge
//   sync      : restart the counter from the effective divider (tie 0 if unused)
//   cfg_div   : new period minus one
//   cfg_en    : new enable
//   tick      : one-cycle pulse per period (registered)
//   pend      : a configuration is waiting for the next terminal count
// -----------------------------------------------------------------------------
module osc_tick_chan
   import osc_tick_pkg::*;
#(
   parameter int CNT_W = OSC_TICK_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acc,
   input  logic             sync,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_en,
   output logic             tick,
   output logic             pend
);

   logic             en_q, en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             pend_en_q, pend_en_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] eff_div;
   logic             eff_en;

   // NOTE: every signal gets its hold value before any branch, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      en_d       = en_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_div_d = pend_div_q;
      pend_en_d  = pend_en_q;
      tick_d     = 1'b0;

      // Configuration that becomes active at the next reload point.
      eff_div = pend_q ? pend_div_q : div_q;
      eff_en  = pend_q ? pend_en_q  : en_q;

      if (sync && (en_q || pend_q)) begin
         // Phase restart: reload from the effective config, suppress this tick.
         cnt_d  = eff_div;
         div_d  = eff_div;
         en_d   = eff_en;
         pend_d = 1'b0;
      end else if (en_q) begin
         if (cnt_q == '0) begin
            // Terminal count: the period completes even if pending disables us.
            tick_d = 1'b1;
            cnt_d  = eff_div;
            div_d  = eff_div;
            en_d   = eff_en;
            pend_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      // Evaluated last so an accept on the terminal (or sync) edge lands in the
      // pending slot rather than merging with the reload above.
      if (acc) begin
         if (en_q) begin
            pend_d     = 1'b1;
            pend_div_d = cfg_div;
            pend_en_d  = cfg_en;
         end else begin
            en_d  = cfg_en;
            div_d = cfg_div;
            cnt_d = cfg_div;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the values computed before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q       <= 1'b0;
         cnt_q      <= '0;
         div_q      <= '0;
         pend_q     <= 1'b0;
         pend_div_q <= '0;
         pend_en_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         en_q       <= en_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_div_q <= pend_div_d;
         pend_en_q  <= pend_en_d;
         tick_q     <= tick_d;
      end
   end

   assign tick = tick_q;
   assign pend = pend_q;

endmodule

// File: rtl/osc_tick_gen.sv
// -----------------------------------------------------------------------------
// osc_tick_gen
// Multi-channel programmable tick generator. Each channel divides clk by
// (div+1) and emits single-cycle tick pulses; reconfiguration through a
// valid/ready handshake is applied glitch-free at the channel's terminal count.
// Parameters: NCH (1..16) channels, CNT_W (2..32) counter width;
//             CH_W = ch_width(NCH) is derived.
// Ports:
//   clk        : oscillator-derived clock, rising edge
//   rst        : asynchronous active-high reset
//   cfg_valid  : configuration request
//   cfg_ready  : request accepted when cfg_valid && cfg_ready
//   cfg_ch     : target channel; indices >= NCH are accepted and dropped
//   cfg_div    : period minus one
//   cfg_en     : channel enable
//   sync       : (only with OSC_TICK_SYNC_EN) restart all running channels
//   tick[NCH]  : one-cycle pulse per channel period
//   busy       : some channel holds a pending configuration
// Build option: define OSC_TICK_SYNC_EN to add the sync input.
// -----------------------------------------------------------------------------
module osc_tick_gen
   import osc_tick_pkg::*;
#(
   parameter  int NCH   = 4,
   parameter  int CNT_W = OSC_TICK_CNT_W,
   localparam int CH_W  = ch_width(NCH)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef OSC_TICK_SYNC_EN
   input  logic             sync,
`endif
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_en,
   output logic [NCH-1:0]   tick,
   output logic             busy
);

   logic [NCH-1:0] pend;
   logic [NCH-1:0] acc;
   logic           sync_int;

`ifdef OSC_TICK_SYNC_EN
   assign sync_int = sync;
`else
   assign sync_int = 1'b0;
`endif

   // Channel decode. An out-of-range index matches nothing, so it reads as
   // ready and the handshake completes without touching any channel.
   always_comb begin
      cfg_ready = 1'b1;
      acc       = '0;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = !pend[i];
            acc[i]    = cfg_valid && !pend[i];
         end
      end
   end

   // OR of pending flops: glitch-free as a registered signal.
   assign busy = |pend;

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      osc_tick_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .acc     (acc[g]),
         .sync    (sync_int),
         .cfg_div (cfg_div),
         .cfg_en  (cfg_en),
         .tick    (tick[g]),
         .pend    (pend[g])
      );
   end

endmodule

// File: tb/tb_osc_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_osc_tick_gen
// Directed bench for osc_tick_gen with NCH=5 (so cfg_ch 5..7 are out of range)
// and CNT_W=16. Inputs change 1 ns after a rising edge; outputs are sampled at
// the same point, so "after edge N" below means the value registered by edge N.
// The sync scenario is compiled in when OSC_TICK_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_osc_tick_gen;
   import osc_tick_pkg::*;

   localparam int NCH   = 5;
   localparam int CNT_W = OSC_TICK_CNT_W;
   localparam int CH_W  = ch_width(NCH);

   logic             clk;
   logic             rst;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_en;
   logic [NCH-1:0]   tick;
   logic             busy;
`ifdef OSC_TICK_SYNC_EN
   logic             sync;
`endif

   int checks = 0;
   int errors = 0;

   osc_tick_gen #(
      .NCH   (NCH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef OSC_TICK_SYNC_EN
      .sync      (sync),
`endif
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .tick      (tick),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for exactly one edge.
   task automatic cfg_write(input logic [CH_W-1:0] ch, input chan_cfg_t c);
      cfg_ch    = ch;
      cfg_div   = c.div;
      cfg_en    = c.en;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   // Reset pulse placed between edges; reset state checked while asserted.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      check({tag, "_tick"}, 32'(tick), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_en    = 1'b0;
`ifdef OSC_TICK_SYNC_EN
      sync      = 1'b0;
`endif
      #3;
      check("por_tick", 32'(tick), 32'd0);
      check("por_busy", 32'(busy), 32'd0);
      check("por_ready", 32'(cfg_ready), 32'd1);
      rst = 1'b0;
      step();

      // ch0 div=3 accepted at edge E: ticks after E+4, E+8, E+12.
      cfg_write(3'd0, '{en: 1'b1, div: 16'd3});
      for (int k = 1; k <= 12; k++) begin
         step();
         check("ch0_div3_tick", 32'(tick), (k % 4 == 0) ? 32'h01 : 32'h00);
      end
      check("ch0_div3_busy", 32'(busy), 32'd0);

      // ch1 div=9, rewritten to div=4 mid-period; applies at E+10.
      do_reset("rst_a");
      cfg_write(3'd1, '{en: 1'b1, div: 16'd9});
      for (int k = 1; k <= 3; k++) step();
      check("ch1_ready_pre", 32'(cfg_ready), 32'd1);
      cfg_write(3'd1, '{en: 1'b1, div: 16'd4});
      check("ch1_ready_pend", 32'(cfg_ready), 32'd0);
      check("ch1_busy_pend", 32'(busy), 32'd1);
      for (int k = 5; k <= 9; k++) begin
         step();
         check("ch1_old_period_tick", 32'(tick), 32'h00);
         check("ch1_old_period_busy", 32'(busy), 32'd1);
      end
      step();
      check("ch1_apply_tick", 32'(tick), 32'h02);
      check("ch1_apply_busy", 32'(busy), 32'd0);
      check("ch1_apply_ready", 32'(cfg_ready), 32'd1);
      for (int k = 1; k <= 10; k++) begin
         step();
         check("ch1_new_period_tick", 32'(tick), (k % 5 == 0) ? 32'h02 : 32'h00);
      end

      // ch2 div=0: tick held high; pending disable gives one more tick.
      do_reset("rst_b");
      cfg_write(3'd2, '{en: 1'b1, div: 16'd0});
      for (int k = 1; k <= 4; k++) begin
         step();
         check("ch2_div0_tick", 32'(tick), 32'h04);
      end
      cfg_write(3'd2, '{en: 1'b0, div: 16'd0});
      check("ch2_dis_term_tick", 32'(tick), 32'h04);
      check("ch2_dis_term_busy", 32'(busy), 32'd1);
      check("ch2_dis_term_ready", 32'(cfg_ready), 32'd0);
      step();
      check("ch2_final_tick", 32'(tick), 32'h04);
      check("ch2_final_busy", 32'(busy), 32'd0);
      check("ch2_final_ready", 32'(cfg_ready), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         step();
         check("ch2_off_tick", 32'(tick), 32'h00);
      end

      // Out-of-range channel: accepted, no effect.
      do_reset("rst_c");
      cfg_ch = 3'd5;
      #1;
      check("oor5_ready", 32'(cfg_ready), 32'd1);
      cfg_ch = 3'd7;
      #1;
      check("oor7_ready", 32'(cfg_ready), 32'd1);
      cfg_write(3'd5, '{en: 1'b1, div: 16'd1});
      cfg_write(3'd7, '{en: 1'b1, div: 16'd0});
      for (int k = 1; k <= 4; k++) begin
         step();
         check("oor_tick", 32'(tick), 32'h00);
         check("oor_busy", 32'(busy), 32'd0);
      end

      // Reset mid-period with a pending write on ch1 and ch0 ticking.
      do_reset("rst_d");
      cfg_write(3'd0, '{en: 1'b1, div: 16'd0});
      cfg_write(3'd1, '{en: 1'b1, div: 16'd9});
      step();
      step();
      cfg_write(3'd1, '{en: 1'b1, div: 16'd4});
      check("pre_rst_tick", 32'(tick), 32'h01);
      check("pre_rst_busy", 32'(busy), 32'd1);
      do_reset("mid_rst");
      for (int k = 1; k <= 3; k++) begin
         step();
         check("post_rst_tick", 32'(tick), 32'h00);
         check("post_rst_busy", 32'(busy), 32'd0);
      end

`ifdef OSC_TICK_SYNC_EN
      // ch0 and ch3 at div=5 started two cycles apart, then aligned by sync.
      do_reset("rst_e");
      cfg_write(3'd0, '{en: 1'b1, div: 16'd5});
      step();
      cfg_write(3'd3, '{en: 1'b1, div: 16'd5});
      step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_edge_tick", 32'(tick), 32'h00);
      for (int k = 1; k <= 18; k++) begin
         step();
         check("sync_aligned_tick", 32'(tick), (k % 6 == 0) ? 32'h09 : 32'h00);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute guard so the run always ends on its own.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
